// File: rtl/matrix_pkg.sv
// matrix_pkg: shared matrix dimensions, stream FSM encoding and index/clamp helpers
package matrix_pkg;
  localparam int MAX_DIM = 5;
  localparam int MAX_ELEMS = MAX_DIM * MAX_DIM;
  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_e;
  function automatic logic [4:0] elem_idx(input logic [2:0] r, input logic [2:0] c);
    return 5'(int'(r) * MAX_DIM + int'(c));
  endfunction
  function automatic logic [2:0] clamp_dim(input logic [2:0] x);
    return (x == 3'd0) ? 3'd1 : (int'(x) > MAX_DIM) ? 3'(MAX_DIM) : x;
  endfunction
endpackage

// File: rtl/matrix_stream_fsm.sv
// matrix_stream_fsm: row-major element walker with valid/ready handshake
//  start/start_slot/start_rows/start_cols : launch a stream (honoured only in IDLE)
//  clear                                  : abort to IDLE
//  out_ready                              : consumer accept
//  slot, out_r, out_c                     : element being presented
//  out_valid, out_last, busy              : handshake / status
module matrix_stream_fsm
  import matrix_pkg::*;
#(
  parameter int SW = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          clear,
  input  logic          out_ready,
  input  logic [SW-1:0] start_slot,
  input  logic [2:0]    start_rows,
  input  logic [2:0]    start_cols,
  output logic [SW-1:0] slot,
  output logic          out_valid,
  output logic          out_last,
  output logic          busy,
  output logic [2:0]    out_r,
  output logic [2:0]    out_c
);
  state_e state_q, state_d;
  logic [2:0] r_q, r_d, c_q, c_d, rows_q, rows_d, cols_q, cols_d;
  logic [SW-1:0] slot_q, slot_d;
  logic fire, last, col_end;
  assign col_end = c_q == cols_q - 3'd1;
  assign last = (r_q == rows_q - 3'd1) && col_end;
  assign fire = (state_q == SEND) && out_ready;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      r_q <= '0;
      c_q <= '0;
      rows_q <= '0;
      cols_q <= '0;
      slot_q <= '0;
    end else begin
      state_q <= state_d;
      r_q <= r_d;
      c_q <= c_d;
      rows_q <= rows_d;
      cols_q <= cols_d;
      slot_q <= slot_d;
    end
  end
  always_comb begin
    state_d = clear ? IDLE : (state_q == IDLE) ? (start ? SEND : IDLE) : (fire && last) ? IDLE : SEND;
  end
  // counters return to 0 whenever the stream ends so IDLE presents zeros
  always_comb begin
    slot_d = slot_q;
    rows_d = rows_q;
    cols_d = cols_q;
    r_d = r_q;
    c_d = c_q;
    if (clear || (fire && last)) begin
      r_d = '0;
      c_d = '0;
    end else if (state_q == IDLE && start) begin
      slot_d = start_slot;
      rows_d = start_rows;
      cols_d = start_cols;
      r_d = '0;
      c_d = '0;
    end else if (fire) begin
      c_d = col_end ? 3'd0 : c_q + 3'd1;
      r_d = col_end ? r_q + 3'd1 : r_q;
    end
  end
  always_comb begin
    busy = state_q == SEND;
    out_valid = busy;
    out_last = busy && last;
    out_r = r_q;
    out_c = c_q;
    slot = slot_q;
  end
endmodule

// File: rtl/matrix_storage_bank.sv
// matrix_storage_bank: captures generator frames into SLOTS slots and streams them row-major
//  frame_in/row_in/col_in/frame_done : incoming frame, captured on frame_done rising edge
//  clear_all                         : empty all slots, abort any stream
//  rd_req/rd_slot                    : start streaming a stored slot
//  out_valid/out_ready/out_data/out_r/out_c/out_last : element stream
//  count/full/busy/err               : occupancy, stream status, error pulse
module matrix_storage_bank
  import matrix_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SLOTS = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [WIDTH*MAX_ELEMS-1:0] frame_in,
  input  logic [2:0]                 row_in,
  input  logic [2:0]                 col_in,
  input  logic                       frame_done,
  input  logic                       clear_all,
  input  logic                       rd_req,
  input  logic [$clog2(SLOTS)-1:0]   rd_slot,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic [2:0]                 out_r,
  output logic [2:0]                 out_c,
  output logic                       out_last,
  output logic [$clog2(SLOTS):0]     count,
  output logic                       full,
  output logic                       busy,
  output logic                       err
);
  localparam int SW = $clog2(SLOTS);
  localparam int CW = SW + 1;
  logic [WIDTH*MAX_ELEMS-1:0] mem_q [0:SLOTS-1];
  logic [2:0] rows_mem_q [0:SLOTS-1];
  logic [2:0] cols_mem_q [0:SLOTS-1];
  logic frame_done_q, frame_done_d, err_q, err_d;
  logic [CW-1:0] count_q, count_d;
  logic cap, wr, slot_ok, start;
  logic [SW-1:0] slot;
  logic [WIDTH*MAX_ELEMS-1:0] cur_frame;
  assign full = count_q == CW'(SLOTS);
  assign count = count_q;
  assign err = err_q;
  always_comb begin
    cap = frame_done && !frame_done_q;
    wr = cap && !full && !clear_all;
    slot_ok = {1'b0, rd_slot} < count_q;
    start = rd_req && !busy && slot_ok && !clear_all;
    frame_done_d = frame_done;
    count_d = clear_all ? '0 : wr ? count_q + 1'b1 : count_q;
    // capture-while-full and bad read in the same cycle merge into one pulse
    err_d = (cap && full && !clear_all) || (rd_req && !busy && !slot_ok);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_done_q <= 1'b0;
      count_q <= '0;
      err_q <= 1'b0;
    end else begin
      frame_done_q <= frame_done_d;
      count_q <= count_d;
      err_q <= err_d;
    end
  end
  // slot contents need no reset; writes only target slot[count], never a streamed slot
  always_ff @(posedge clk) begin
    if (wr) begin
      mem_q[count_q[SW-1:0]] <= frame_in;
      rows_mem_q[count_q[SW-1:0]] <= clamp_dim(row_in);
      cols_mem_q[count_q[SW-1:0]] <= clamp_dim(col_in);
    end
  end
  matrix_stream_fsm #(.SW(SW)) u_fsm (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .clear      (clear_all),
    .out_ready  (out_ready),
    .start_slot (rd_slot),
    .start_rows (rows_mem_q[rd_slot]),
    .start_cols (cols_mem_q[rd_slot]),
    .slot       (slot),
    .out_valid  (out_valid),
    .out_last   (out_last),
    .busy       (busy),
    .out_r      (out_r),
    .out_c      (out_c)
  );
  assign cur_frame = mem_q[slot];
  assign out_data = busy ? cur_frame[int'(elem_idx(out_r, out_c))*WIDTH +: WIDTH] : '0;
endmodule

// File: tb/tb_matrix_storage_bank.sv
// tb_matrix_storage_bank: vector table, directed corner sequences and random ops against a slot model
module tb_matrix_storage_bank;
  localparam int W = 8;
  localparam int S = 4;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [W*25-1:0] frame_in = '0;
  logic [2:0] row_in = '0, col_in = '0;
  logic frame_done = 1'b0, clear_all = 1'b0, rd_req = 1'b0, out_ready = 1'b0;
  logic [1:0] rd_slot = '0;
  logic out_valid, out_last, full, busy, err;
  logic [W-1:0] out_data;
  logic [2:0] out_r, out_c;
  logic [2:0] count;
  int tests = 0, failed = 0;
  int mdl_mem [S][25];
  int mdl_rows [S];
  int mdl_cols [S];
  int mdl_count = 0;
  int nf [25];
  int last_r, last_c, last_d;
  typedef struct {int ri; int ci; int er; int ec;} vec_t;
  vec_t vecs [6];
  always #5 clk = ~clk;
  matrix_storage_bank #(.WIDTH(W), .SLOTS(S)) dut (
    .clk(clk), .rst_n(rst_n), .frame_in(frame_in), .row_in(row_in), .col_in(col_in),
    .frame_done(frame_done), .clear_all(clear_all), .rd_req(rd_req), .rd_slot(rd_slot),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_r(out_r),
    .out_c(out_c), .out_last(out_last), .count(count), .full(full), .busy(busy), .err(err)
  );
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  function automatic int tb_clamp(input int x);
    if (x < 1) return 1;
    if (x > 5) return 5;
    return x;
  endfunction
  task automatic rand_frame();
    for (int k = 0; k < 25; k++) nf[k] = $urandom_range(0, 255);
  endtask
  task automatic do_capture(input int ri, input int ci, input int hold);
    logic exp_err;
    for (int k = 0; k < 25; k++) frame_in[k*W +: W] = W'(nf[k]);
    row_in = 3'(ri);
    col_in = 3'(ci);
    frame_done = 1'b1;
    exp_err = mdl_count == S;
    if (!exp_err) begin
      mdl_mem[mdl_count] = nf;
      mdl_rows[mdl_count] = tb_clamp(ri);
      mdl_cols[mdl_count] = tb_clamp(ci);
      mdl_count++;
    end
    @(negedge clk);
    check("cap_err", err, exp_err);
    check("cap_count", count, mdl_count);
    check("cap_full", full, mdl_count == S);
    for (int i = 1; i < hold; i++) begin
      @(negedge clk);
      check("hold_err", err, 0);
      check("hold_count", count, mdl_count);
    end
    frame_done = 1'b0;
    @(negedge clk);
    check("post_cap_err", err, 0);
  endtask
  task automatic do_clear();
    clear_all = 1'b1;
    @(negedge clk);
    clear_all = 1'b0;
    mdl_count = 0;
    check("clear_count", count, 0);
    check("clear_full", full, 0);
  endtask
  task automatic do_stream(input int slot, input int mode);
    int exp_n, idx, cyc, er, ec, pd;
    logic rdy, stalled;
    rd_slot = 2'(slot);
    rd_req = 1'b1;
    @(negedge clk);
    rd_req = 1'b0;
    if (slot >= mdl_count) begin
      check("bad_err", err, 1);
      check("bad_busy", busy, 0);
      check("bad_valid", out_valid, 0);
      @(negedge clk);
      check("bad_err_drop", err, 0);
      check("bad_valid2", out_valid, 0);
      return;
    end
    check("start_err", err, 0);
    exp_n = mdl_rows[slot] * mdl_cols[slot];
    idx = 0;
    cyc = 0;
    pd = 0;
    stalled = 1'b0;
    while (idx < exp_n) begin
      if (cyc >= 400) begin
        check("stream_timeout", 1, 0);
        break;
      end
      if (out_valid !== 1'b1) begin
        check("stream_valid", out_valid, 1);
        break;
      end
      er = idx / mdl_cols[slot];
      ec = idx % mdl_cols[slot];
      check("data", out_data, mdl_mem[slot][er*5+ec]);
      check("out_r", out_r, er);
      check("out_c", out_c, ec);
      check("out_last", out_last, idx == exp_n - 1);
      if (stalled) check("stall_data", out_data, pd);
      rdy = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 2 == 0) : 1'($urandom_range(0, 1));
      out_ready = rdy;
      if (out_last) begin
        last_r = out_r;
        last_c = out_c;
        last_d = out_data;
      end
      if (rdy) begin
        idx++;
        stalled = 1'b0;
      end else begin
        stalled = 1'b1;
        pd = out_data;
      end
      @(negedge clk);
      cyc++;
    end
    out_ready = 1'b0;
    check("beats", idx, exp_n);
    check("end_valid", out_valid, 0);
    check("end_busy", busy, 0);
  endtask
  initial begin
    vecs[0] = '{2, 3, 2, 3};
    vecs[1] = '{0, 7, 1, 5};
    vecs[2] = '{5, 5, 5, 5};
    vecs[3] = '{1, 1, 1, 1};
    vecs[4] = '{6, 0, 5, 1};
    vecs[5] = '{4, 2, 4, 2};
    repeat (3) @(negedge clk);
    check("rst_count", count, 0);
    check("rst_full", full, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err, 0);
    check("rst_valid", out_valid, 0);
    check("rst_data", out_data, 0);
    check("rst_r", out_r, 0);
    check("rst_c", out_c, 0);
    check("rst_last", out_last, 0);
    rst_n = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 25; k++) nf[k] = k + 1;
    do_capture(2, 3, 10);
    check("t1_count", count, 1);
    do_stream(0, 0);
    check("t1_last_data", last_d, 8);
    check("t1_last_r", last_r, 1);
    check("t1_last_c", last_c, 2);
    for (int i = 0; i < 3; i++) begin
      rand_frame();
      do_capture($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(1, 3));
    end
    check("t2_full", full, 1);
    rand_frame();
    do_capture(3, 3, 3);
    check("t2_count", count, 4);
    do_stream(3, 0);
    do_stream(0, 1);
    do_clear();
    rand_frame();
    do_capture(3, 2, 1);
    do_stream(2, 0);
    check("t4_busy", busy, 0);
    do_clear();
    rand_frame();
    do_capture(5, 5, 2);
    do_stream(0, 1);
    do_clear();
    rand_frame();
    do_capture(5, 5, 1);
    rd_slot = 2'd0;
    rd_req = 1'b1;
    @(negedge clk);
    rd_req = 1'b0;
    out_ready = 1'b1;
    check("t5_valid0", out_valid, 1);
    @(negedge clk);
    @(negedge clk);
    check("t5_beat3", out_data, mdl_mem[0][2]);
    clear_all = 1'b1;
    frame_done = 1'b1;
    @(negedge clk);
    clear_all = 1'b0;
    out_ready = 1'b0;
    check("t5_valid", out_valid, 0);
    check("t5_count", count, 0);
    check("t5_busy", busy, 0);
    check("t5_err", err, 0);
    @(negedge clk);
    check("t5_count_hold", count, 0);
    frame_done = 1'b0;
    mdl_count = 0;
    @(negedge clk);
    foreach (vecs[i]) begin
      do_clear();
      rand_frame();
      do_capture(vecs[i].ri, vecs[i].ci, 1);
      do_stream(0, 2);
      check("vec_last_r", last_r, vecs[i].er - 1);
      check("vec_last_c", last_c, vecs[i].ec - 1);
    end
    for (int it = 0; it < 40; it++) begin
      case ($urandom_range(0, 7))
        0: do_clear();
        1, 2, 3: begin
          rand_frame();
          do_capture($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(1, 3));
        end
        default: do_stream($urandom_range(0, 3), 2);
      endcase
    end
    do_clear();
    rand_frame();
    do_capture(0, 7, 2);
    rd_slot = 2'd0;
    rd_req = 1'b1;
    @(negedge clk);
    rd_req = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check("t6_busy", busy, 1);
    check("t6_r", out_r, 0);
    check("t6_c", out_c, 2);
    rst_n = 1'b0;
    #1;
    check("t6_valid", out_valid, 0);
    check("t6_busy0", busy, 0);
    check("t6_count", count, 0);
    check("t6_data", out_data, 0);
    check("t6_rc", {out_r, out_c}, 0);
    check("t6_last", out_last, 0);
    check("t6_err", err, 0);
    @(negedge clk);
    rst_n = 1'b1;
    mdl_count = 0;
    @(negedge clk);
    check("t6_after_count", count, 0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
